axi4l_reg64_writer: RTL and testbench
=====================================

Name: axi4l_reg64_writer

Overview:
- AXI4-Lite write-only master that sits directly upstream of the 64-bit register bank slave.
- Accepts a 64-bit value on a valid/ready stream and issues two 32-bit AXI4-Lite writes:
  - high word to BASE_ADDR+0;
  - low word to BASE_ADDR+4.
- The register bank stores word 0 as bits [63:32] and word 4 as bits [31:0].
- Reports completion and any error response, one request at a time.

Parameters:
- ADDR_WIDTH, 3, width of awaddr.
- BASE_ADDR, 0, byte address of the high word; must be 8-byte aligned.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  synchronous, active-high reset.
- in_valid  in  1  64-bit write request valid.
- in_ready  out  1  block can accept a request.
- in_data  in  64  value to write.
- done  out  1  one-cycle pulse: both writes completed.
- err  out  1  valid with done; 1 if either B response was not OKAY.
- awvalid  out  1  AXI write address valid.
- awready  in  1  AXI write address ready.
- awaddr  out  ADDR_WIDTH  AXI write byte address.
- awprot  out  3  constant 3'b000.
- wvalid  out  1  AXI write data valid.
- wready  in  1  AXI write data ready.
- wdata  out  32  AXI write data.
- wstrb  out  4  constant 4'b1111.
- bvalid  in  1  AXI write response valid.
- bready  out  1  AXI write response ready.
- bresp  in  2  AXI write response.

Behaviour:
- Clock and reset: one clock (aclk); reset areset is synchronous and active-high.
- Reset values: in_ready=0, done=0, err=0, awvalid=0, wvalid=0, bready=0, awaddr=0, wdata=0. State goes to IDLE; in_ready rises the cycle after areset deasserts.
- Reset mid-operation: the next edge forces IDLE and drops all valids. The outstanding transaction is abandoned; the slave is reset together with the block.
- States: IDLE, HI_AW_W, HI_B, LO_AW_W, LO_B, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: capture in_data into a 64-bit holding register and clear the internal error flag.
  - Drive awaddr=BASE_ADDR, wdata=in_data[63:32], awvalid=1, wvalid=1; go to HI_AW_W.
- HI_AW_W / LO_AW_W: address and write channels complete independently.
  - awvalid drops the cycle after (awvalid & awready); wvalid drops the cycle after (wvalid & wready).
  - Both handshakes may happen in the same cycle, or in either order.
  - Once both are done (including the handshake cycle itself): bready=1; go to HI_B / LO_B.
  - No valid is withdrawn before its handshake; awaddr and wdata stay stable while their valid is high.
- HI_B:
  - On bvalid & bready: error flag |= (bresp != 2'b00); bready=0.
  - Drive awaddr=BASE_ADDR+4, wdata=hold[31:0], awvalid=1, wvalid=1; go to LO_AW_W.
  - The low word is always issued, even after a high-word error.
- LO_B: on bvalid & bready, fold bresp into the error flag; bready=0; go to DONE.
- DONE:
  - done=1 and err=flag for exactly one cycle; then IDLE.
  - in_ready stays 0 in DONE, so the minimum interval between accepts is the full transaction plus one cycle.
- bready is 1 only in HI_B and LO_B. A bvalid arriving in any other state is ignored and not acknowledged.
- in_data changes while busy have no effect.
- Address arithmetic is modulo 2^ADDR_WIDTH.
- Latency: in_valid accept → first awvalid on the next cycle. Against the register bank (1-cycle ready, wr_ack 2 cycles after wr_req, bvalid next cycle), done follows about 12 cycles after accept.

Test Plan:
- Basic write against the register bank, in_data=64'h1122_3344_5566_7788:
  - awaddr=0, wdata=32'h11223344, then awaddr=4, wdata=32'h55667788;
  - done pulses once with err=0; register1_o=64'h1122334455667788 from then on.
- Channel skew:
  - awready held 0 for 3 cycles while wready=1 → wvalid drops after 1 cycle, awvalid stays high with stable awaddr until the handshake, and exactly one B is consumed per word.
  - Repeat with wready delayed 5 cycles and awready immediate.
- Error response: model returns bresp=2'b10 on the high word and 2'b00 on the low word → low word still written, done=1 with err=1. The next request returning OKAY on both gives err=0 (flag cleared).
- Back-to-back: in_valid held high with values A then B → in_ready=0 from accept through DONE; B accepted the first IDLE cycle after A's done; register bank holds B at the end.
- Reset mid-operation: areset asserted while in LO_B → next cycle awvalid=wvalid=bready=0 and done=0. After release, in_ready=1 and a new write completes normally.
- Protocol checker on all runs:
  - no valid drops before its handshake;
  - awprot=0 and wstrb=4'hF throughout;
  - no bready outside the B states.

Source files
------------

// File: rtl/axi4l_reg64_writer.sv
// axi4l_reg64_writer
//   AXI4-Lite write-only master feeding a 64-bit register bank. Each accepted
//   64-bit request becomes two 32-bit writes: the high word to BASE_ADDR+0,
//   then the low word to BASE_ADDR+4. done pulses for one cycle when both
//   B responses are in; err reports whether either response was not OKAY.
//
// Ports:
//   aclk, areset         clock, synchronous active-high reset
//   in_valid/in_ready    64-bit request handshake, in_data is the value
//   done, err            completion pulse and its error status
//   aw*/w*/b*            AXI4-Lite write address, data and response channels
module axi4l_reg64_writer #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [63:0]           in_data,
  output logic                  done,
  output logic                  err,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic [2:0]            awprot,
  output logic                  wvalid,
  input  logic                  wready,
  output logic [31:0]           wdata,
  output logic [3:0]            wstrb,
  input  logic                  bvalid,
  output logic                  bready,
  input  logic [1:0]            bresp
);

  typedef enum logic [2:0] {
    IDLE,
    HI_AW_W,
    HI_B,
    LO_AW_W,
    LO_B,
    DONE
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] ADDR_HI = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LO = ADDR_HI + ADDR_WIDTH'(4);

  state_e                  state_q, state_d;
  // The high word goes straight to wdata on accept, so only the low word
  // needs to be held for the second write.
  logic [31:0]             lo_hold_q, lo_hold_d;
  logic                    flag_q, flag_d;
  logic                    in_ready_q, in_ready_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic                    bready_q, bready_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [31:0]             wdata_q, wdata_d;

  always_comb begin
    state_d   = state_q;
    lo_hold_d = lo_hold_q;
    flag_d    = flag_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;

    unique case (state_q)
      IDLE: begin
        if (in_ready_q && in_valid) begin
          lo_hold_d = in_data[31:0];
          flag_d    = 1'b0;
          awaddr_d  = ADDR_HI;
          wdata_d   = in_data[63:32];
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = HI_AW_W;
        end
      end
      HI_AW_W, LO_AW_W: begin
        // Each channel retires on its own handshake; move on once neither
        // valid will remain set after this edge.
        if (awvalid_q && awready) awvalid_d = 1'b0;
        if (wvalid_q && wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = (state_q == HI_AW_W) ? HI_B : LO_B;
        end
      end
      HI_B: begin
        if (bvalid && bready_q) begin
          flag_d    = flag_q | (bresp != 2'b00);
          bready_d  = 1'b0;
          awaddr_d  = ADDR_LO;
          wdata_d   = lo_hold_q;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = LO_AW_W;
        end
      end
      LO_B: begin
        if (bvalid && bready_q) begin
          flag_d   = flag_q | (bresp != 2'b00);
          bready_d = 1'b0;
          done_d   = 1'b1;
          err_d    = flag_d;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Registered so in_ready stays low for the first cycle out of reset.
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= IDLE;
      lo_hold_q  <= '0;
      flag_q     <= 1'b0;
      in_ready_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      lo_hold_q  <= lo_hold_d;
      flag_q     <= flag_d;
      in_ready_q <= in_ready_d;
      done_q     <= done_d;
      err_q      <= err_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      bready_q   <= bready_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign in_ready = in_ready_q;
  assign done     = done_q;
  assign err      = err_q;
  assign awvalid  = awvalid_q;
  assign awaddr   = awaddr_q;
  assign awprot   = 3'b000;
  assign wvalid   = wvalid_q;
  assign wdata    = wdata_q;
  assign wstrb    = 4'b1111;
  assign bready   = bready_q;

endmodule

// File: tb/tb_axi4l_reg64_writer.sv
module tb_axi4l_reg64_writer;

  logic        aclk;
  logic        areset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        done;
  logic        err;
  logic        awvalid;
  logic        awready;
  logic [2:0]  awaddr;
  logic [2:0]  awprot;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;

  axi4l_reg64_writer #(.ADDR_WIDTH(3), .BASE_ADDR(0)) dut (
    .aclk(aclk), .areset(areset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .done(done), .err(err),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: expected writes and expected err per request.
  typedef struct {
    logic [2:0]  addr;
    logic [31:0] data;
  } wr_t;
  wr_t  exp_wr[$];
  logic exp_err[$];
  wr_t  sb_w;

  // Slave / register bank model configuration.
  int unsigned aw_dly, w_dly;
  logic [1:0]  resp_hi, resp_lo;
  logic [63:0] reg_model;
  int unsigned aw_wait, w_wait;
  logic        got_aw, got_w;
  logic [2:0]  cap_addr;
  logic [31:0] cap_data;
  int          b_cnt = 0;
  int          done_cnt = 0;

  always @(posedge aclk) begin
    if (areset) begin
      awready <= 1'b0; wready <= 1'b0; bvalid <= 1'b0; bresp <= 2'b00;
      aw_wait <= 0; w_wait <= 0; got_aw <= 1'b0; got_w <= 1'b0;
      cap_addr <= '0; cap_data <= '0; reg_model <= '0;
    end else begin
      if (awvalid && awready) begin
        got_aw <= 1'b1; cap_addr <= awaddr; awready <= 1'b0; aw_wait <= 0;
      end else if (awvalid && !got_aw && !awready) begin
        if (aw_wait >= aw_dly) awready <= 1'b1;
        else aw_wait <= aw_wait + 1;
      end
      if (wvalid && wready) begin
        got_w <= 1'b1; cap_data <= wdata; wready <= 1'b0; w_wait <= 0;
      end else if (wvalid && !got_w && !wready) begin
        if (w_wait >= w_dly) wready <= 1'b1;
        else w_wait <= w_wait + 1;
      end
      if (got_aw && got_w && !bvalid) begin
        got_aw <= 1'b0; got_w <= 1'b0; bvalid <= 1'b1;
        bresp <= (cap_addr == 3'd0) ? resp_hi : resp_lo;
        if (cap_addr == 3'd0) reg_model[63:32] <= cap_data;
        else                  reg_model[31:0]  <= cap_data;
        if (exp_wr.size() == 0) begin
          chk("sb_unexpected_write", 1, 0);
        end else begin
          sb_w = exp_wr.pop_front();
          chk("awaddr", {61'd0, cap_addr}, {61'd0, sb_w.addr});
          chk("wdata", {32'd0, cap_data}, {32'd0, sb_w.data});
        end
      end
      if (bvalid && bready) begin
        bvalid <= 1'b0;
        b_cnt++;
      end
    end
  end

  // Done monitor: each done cycle pops one expected err.
  always @(negedge aclk) begin
    if (!areset && done) begin
      done_cnt++;
      if (exp_err.size() == 0) chk("done_unexpected", 1, 0);
      else chk("done_err", {63'd0, err}, {63'd0, exp_err.pop_front()});
    end
  end

  // Protocol checker.
  logic       p_aw = 1'b0, p_w = 1'b0;
  logic [2:0]  p_addr;
  logic [31:0] p_data;
  always @(posedge aclk) begin
    if (p_aw) chk("aw_hold", {awvalid, 58'd0, awaddr}, {1'b1, 58'd0, p_addr});
    if (p_w)  chk("w_hold", {31'd0, wvalid, wdata}, {31'd0, 1'b1, p_data});
    if (awprot !== 3'b000) chk("awprot", {61'd0, awprot}, 0);
    if (wstrb !== 4'hf)    chk("wstrb", {60'd0, wstrb}, 64'hf);
    if (bready && (awvalid || wvalid)) chk("bready_outside_b", 1, 0);
    p_aw   <= awvalid && !awready && !areset;
    p_w    <= wvalid && !wready && !areset;
    p_addr <= awaddr;
    p_data <= wdata;
  end

  task automatic send(input logic [63:0] d, input logic e);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin @(negedge aclk); n++; end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    in_valid = 1'b1;
    in_data  = d;
    exp_wr.push_back('{3'd0, d[63:32]});
    exp_wr.push_back('{3'd4, d[31:0]});
    exp_err.push_back(e);
    @(negedge aclk);
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom};
    chk("in_ready_after_accept", {63'd0, in_ready}, 0);
  endtask

  task automatic wait_done(input int start);
    int n;
    n = 0;
    while (done_cnt == start && n < 300) begin @(posedge aclk); n++; end
    if (done_cnt == start) chk("done_timeout", 0, 1);
    @(negedge aclk);
  endtask

  typedef struct {
    logic [63:0] data;
    logic [1:0]  r_hi;
    logic [1:0]  r_lo;
    int unsigned awd;
    int unsigned wd;
    logic        e;
  } vec_t;
  vec_t vecs[8];

  initial begin
    int d0, b0, n;
    logic [63:0] va, vb;
    logic busy_ok;

    vecs[0] = '{64'h1122_3344_5566_7788, 2'b00, 2'b00, 0, 0, 1'b0};
    vecs[1] = '{64'hdead_beef_0bad_f00d, 2'b00, 2'b00, 3, 0, 1'b0};
    vecs[2] = '{64'h0123_4567_89ab_cdef, 2'b00, 2'b00, 0, 5, 1'b0};
    vecs[3] = '{64'hcafe_0001_cafe_0002, 2'b10, 2'b00, 1, 2, 1'b1};
    vecs[4] = '{64'h5a5a_a5a5_3c3c_c3c3, 2'b00, 2'b00, 0, 0, 1'b0};
    vecs[5] = '{64'h8000_0000_0000_0001, 2'b00, 2'b11, 2, 2, 1'b1};
    vecs[6] = '{64'h0000_0000_ffff_ffff, 2'b01, 2'b01, 4, 1, 1'b1};
    vecs[7] = '{64'hffff_ffff_ffff_ffff, 2'b00, 2'b00, 0, 3, 1'b0};

    areset = 1'b1; in_valid = 1'b0; in_data = '0;
    aw_dly = 0; w_dly = 0; resp_hi = 2'b00; resp_lo = 2'b00;
    repeat (3) @(negedge aclk);
    chk("rst_in_ready", {63'd0, in_ready}, 0);
    chk("rst_done_err", {62'd0, done, err}, 0);
    chk("rst_valids", {61'd0, awvalid, wvalid, bready}, 0);
    chk("rst_addr_data", {29'd0, awaddr, wdata}, 0);
    areset = 1'b0;
    @(negedge aclk);
    chk("in_ready_after_reset", {63'd0, in_ready}, 1);

    for (int i = 0; i < 8; i++) begin
      aw_dly = vecs[i].awd; w_dly = vecs[i].wd;
      resp_hi = vecs[i].r_hi; resp_lo = vecs[i].r_lo;
      d0 = done_cnt; b0 = b_cnt;
      send(vecs[i].data, vecs[i].e);
      wait_done(d0);
      chk("reg_value", reg_model, vecs[i].data);
      chk("b_per_request", b_cnt - b0, 2);
    end

    // Back-to-back with in_valid held high; in_data changes while busy.
    aw_dly = 0; w_dly = 0; resp_hi = 2'b00; resp_lo = 2'b00;
    va = 64'haaaa_0000_bbbb_1111;
    vb = 64'h1234_5678_9abc_def0;
    d0 = done_cnt;
    in_valid = 1'b1; in_data = va;
    exp_wr.push_back('{3'd0, va[63:32]});
    exp_wr.push_back('{3'd4, va[31:0]});
    exp_err.push_back(1'b0);
    @(negedge aclk);
    chk("b2b_accept_a", {63'd0, in_ready}, 0);
    in_data = vb;
    busy_ok = 1'b1;
    n = 0;
    while (!done && n < 100) begin
      @(negedge aclk);
      if (in_ready) busy_ok = 1'b0;
      n++;
    end
    chk("b2b_in_ready_low_busy", {63'd0, busy_ok}, 1);
    chk("b2b_done_a", {63'd0, done}, 1);
    @(negedge aclk);
    chk("b2b_ready_after_done", {63'd0, in_ready}, 1);
    exp_wr.push_back('{3'd0, vb[63:32]});
    exp_wr.push_back('{3'd4, vb[31:0]});
    exp_err.push_back(1'b0);
    @(negedge aclk);
    in_valid = 1'b0;
    chk("b2b_accept_b", {63'd0, in_ready}, 0);
    wait_done(d0 + 1);
    chk("b2b_reg_b", reg_model, vb);

    // Reset while waiting for the low-word response.
    send(64'h7777_6666_5555_4444, 1'b0);
    n = 0;
    while (!(bready && cap_addr == 3'd4) && n < 100) begin @(negedge aclk); n++; end
    chk("reach_lo_b", {63'd0, bready}, 1);
    areset = 1'b1;
    exp_wr.delete();
    exp_err.delete();
    @(negedge aclk);
    chk("midrst_valids", {61'd0, awvalid, wvalid, bready}, 0);
    chk("midrst_done", {62'd0, done, in_ready}, 0);
    @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    chk("midrst_in_ready", {63'd0, in_ready}, 1);
    d0 = done_cnt;
    send(64'h0f0f_f0f0_1357_9bdf, 1'b0);
    wait_done(d0);
    chk("post_rst_reg", reg_model, 64'h0f0f_f0f0_1357_9bdf);

    repeat (3) @(negedge aclk);
    chk("sb_drained", exp_wr.size() + exp_err.size(), 0);
    chk("no_extra_done", {63'd0, done}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
